// File: rtl/sipo_register.sv
// Serial-in parallel-out deserializer: LSB-first bits are assembled into WIDTH-bit words on a valid/ready holding stage.
// Define SIPO_REGISTER_PARITY_EN to append one even-parity bit per frame and report parity_err.
module sipo_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SIPO_REGISTER_PARITY_EN
    typedef enum logic [0:0] {COLLECT, PARITY} state_t;
`else
    typedef enum logic [0:0] {COLLECT} state_t;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [WIDTH-1:0] word;
    logic             perr;
    logic             complete;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shift_n  = shift_q;
        word     = {serial_in, shift_q[WIDTH-1:1]};
        perr     = 1'b0;
        complete = 1'b0;
        if (frame_start) begin
            // Resync: stale bits fall out of the register before the new frame can complete.
            state_n = COLLECT;
            if (serial_valid) begin
                shift_n = word;
                cnt_n   = CNT_W'(1);
            end else begin
                cnt_n = '0;
            end
        end else if (serial_valid) begin
`ifdef SIPO_REGISTER_PARITY_EN
            if (state == PARITY) begin
                word     = shift_q;
                perr     = (^shift_q) ^ serial_in;
                complete = 1'b1;
                cnt_n    = '0;
                state_n  = COLLECT;
            end else
`endif
            begin
                shift_n = word;
                if (cnt == LAST_BIT) begin
`ifdef SIPO_REGISTER_PARITY_EN
                    state_n = PARITY;
                    cnt_n   = CNT_W'(WIDTH);
`else
                    complete = 1'b1;
                    cnt_n    = '0;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COLLECT;
            cnt          <= '0;
            shift_q      <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift_q <= shift_n;
            overrun <= 1'b0;
            if (complete) begin
                // A word completing against a stalled holding stage is dropped; the held word wins.
                if (!out_valid || out_ready) begin
                    parallel_out <= word;
                    parity_err   <= perr;
                    out_valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
